proc_trace_monitor: RTL
=======================

# proc_trace_monitor

Synthesizable run monitor for the accumulator processor: per-commit trace capture, cycle/instruction counting, halt detection and watchdog timeout, with post-mortem readout. Sits beside `riscv_simple_processor` and taps its PC, IR, ACC, commit strobe and halt. Replaces bench-only `$monitor` and timeout logic with hardware usable on FPGA and in regression. Generalised over address/data width, trace depth and timeout.

## Interface
- `AWIDTH`, 5: PC width.
- `DWIDTH`, 8: IR/ACC width.
- `DEPTH`, 16: trace entries. Power of two, ≥2.
- `TIMEOUT`, 1000000: watchdog limit in enabled cycles. Must be <2^CNT_W.
- `CNT_W`, 32: counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `en_i` in 1: capture/count enable.
- `clear_i` in 1: synchronous clear to IDLE.
- `commit_i` in 1: instruction-commit strobe (CU `ld_ir`).
- `halt_i` in 1: CU halt.
- `pc_i` in AWIDTH, `ir_i` in DWIDTH, `acc_i` in DWIDTH: sampled on commit.
- `rd_req_i` in 1: pop oldest trace entry.
- `rd_data_o` out 2*DWIDTH+AWIDTH: {pc, ir, acc}, MSB first.
- `rd_valid_o` out 1: `rd_data_o` valid this cycle.
- `count_o` out $clog2(DEPTH)+1: entries held.
- `overflow_o` out 1: sticky, set when an entry was overwritten.
- `cycle_cnt_o` out CNT_W: enabled cycles in RUN.
- `instr_cnt_o` out CNT_W: commits recorded, saturating at all-ones.
- `state_o` out 2: FSM state.

## Operation
- States: IDLE=00, RUN=01, HALTED=10, TIMEOUT=11.
- IDLE → RUN when `en_i`=1. No capture in IDLE.
- RUN, `en_i`=1:
  - `cycle_cnt` increments each cycle.
  - On `commit_i`, push {pc_i, ir_i, acc_i} and increment `instr_cnt`.
- RUN, `en_i`=0: counters and capture frozen. State is held.
- RUN → HALTED when `halt_i`=1.
- RUN → TIMEOUT on an enabled cycle where `cycle_cnt` = TIMEOUT-1. `cycle_cnt` ends at TIMEOUT.
- Halt and timeout in the same cycle: HALTED wins.
- Commit in the same cycle as halt or timeout: the entry is recorded, then the state transitions.
- HALTED and TIMEOUT:
  - Capture and counters frozen.
  - Readout enabled.
  - Sticky until `clear_i` or reset.
- Trace ring behaviour:
  - Push when full overwrites the oldest entry; `count_o` stays at DEPTH and `overflow_o` is set.
  - Write and read pointers wrap modulo DEPTH.
- Pop (`rd_req_i`) rules:
  - Honoured only in HALTED/TIMEOUT with `count_o`>0. Returns the oldest entry and decrements `count_o`.
  - Pop while empty, or in IDLE/RUN, is ignored: no `rd_valid_o`, no pointer change.
- `clear_i`:
  - Priority over all other inputs.
  - Next cycle: IDLE; pointers, counts, `overflow_o`, `cycle_cnt`, `instr_cnt` at 0.
- Reset values (all outputs): `state_o`=IDLE, `count_o`=0, `overflow_o`=0, both counters 0, `rd_valid_o`=0, `rd_data_o`=0.
- Reset mid-run or mid-readout discards all trace content immediately.

## Timing
- Commit at edge N: entry is written at edge N. `count_o` and `instr_cnt_o` reflect it after edge N.
- `halt_i` sampled at edge N: `state_o`=HALTED after edge N. The commit at edge N is included.
- `rd_req_i` sampled at edge N: `rd_data_o` registered and `rd_valid_o`=1 for the cycle after edge N. One-cycle latency.
- Back-to-back pops give one entry per cycle.
- `rd_valid_o` is a single-cycle pulse per accepted pop. `rd_data_o` holds its last value otherwise.
- All outputs are registered. No combinational input→output paths.

## Structure
- Package `trace_mon_pkg`:
  - state encoding localparams;
  - `TRACE_ENTRY_W` = 2*DWIDTH+AWIDTH;
  - count-width macro or function.
- Width defines come from `parameters.vh` (`AWIDTH`, `DWIDTH`) as parameter defaults.
- One sub-module, `trace_ring_buffer`:
  - parametrised DEPTH×WIDTH circular store;
  - overwrite-on-full;
  - registered read port, count, overflow flag.
- FSM and counters live in the top.

## Test plan
- Reset, `en_i`=1, 5 commits with PC 0..4 and ACC 10,20,..,50, then `halt_i` → `state_o`=10, `count_o`=5, `instr_cnt_o`=5. Five pops return PC 0..4 in order, `rd_valid_o` one cycle after each request.
- DEPTH=4, 6 commits (PC 0..5) then halt → `count_o`=4, `overflow_o`=1, pops return PC 2,3,4,5.
- TIMEOUT=20, no halt → `state_o`=11 after 20 enabled cycles, `cycle_cnt_o`=20. Commits afterwards are ignored.
- Halt, timeout and commit in the same cycle → state HALTED, commit recorded. `en_i` low for 3 cycles in RUN → `cycle_cnt_o` does not advance.
- Pop while empty and pop during RUN → no `rd_valid_o`, `count_o` unchanged. `clear_i` in HALTED with 3 entries → IDLE, all counts 0 next cycle.
- Assert `rst`=0 mid-readout → all outputs at reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/trace_mon_pkg.sv
// Shared definitions for the processor run monitor: state encoding,
// default tap widths and width helpers.
package trace_mon_pkg;

    localparam int unsigned DEF_AWIDTH    = 5;
    localparam int unsigned DEF_DWIDTH    = 8;
    localparam int unsigned TRACE_ENTRY_W = 2 * DEF_DWIDTH + DEF_AWIDTH;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'b00;
    localparam state_t ST_RUN     = 2'b01;
    localparam state_t ST_HALTED  = 2'b10;
    localparam state_t ST_TIMEOUT = 2'b11;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
        return 2 * dw + aw;
    endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular trace store: overwrite-on-full, registered read port,
// occupancy count and sticky overflow flag.
module trace_ring_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full_c;
    logic             pop_ok_c;
    logic             wrap_c;

    assign full_c   = (count == CW'(DEPTH));
    assign pop_ok_c = pop && (count != '0);
    // A push into a full ring drops the oldest entry by advancing the read side.
    assign wrap_c   = push && full_c && !pop_ok_c;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok_c;
            if (pop_ok_c) begin
                rd_data <= mem[rd_ptr];
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c || wrap_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wrap_c) begin
                overflow <= 1'b1;
            end
            if (push && !full_c && !pop_ok_c) begin
                count <= count + CW'(1);
            end else if (pop_ok_c && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/proc_trace_monitor.sv
// Run monitor for the accumulator processor: commit trace capture,
// cycle/instruction counters, halt and watchdog detection, post-mortem readout.
module proc_trace_monitor
    import trace_mon_pkg::*;
#(
    parameter int unsigned AWIDTH  = DEF_AWIDTH,
    parameter int unsigned DWIDTH  = DEF_DWIDTH,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_i,
    input  logic                              clear_i,
    input  logic                              commit_i,
    input  logic                              halt_i,
    input  logic [AWIDTH-1:0]                 pc_i,
    input  logic [DWIDTH-1:0]                 ir_i,
    input  logic [DWIDTH-1:0]                 acc_i,
    input  logic                              rd_req_i,
    output logic [entry_width(AWIDTH, DWIDTH)-1:0] rd_data_o,
    output logic                              rd_valid_o,
    output logic [cnt_width(DEPTH)-1:0]       count_o,
    output logic                              overflow_o,
    output logic [CNT_W-1:0]                  cycle_cnt_o,
    output logic [CNT_W-1:0]                  instr_cnt_o,
    output logic [1:0]                        state_o
);

    localparam int unsigned ENTRY_W = entry_width(AWIDTH, DWIDTH);

    state_t             state;
    state_t             state_nxt;
    logic               push_c;
    logic               pop_c;
    logic               run_c;
    logic               timeout_hit_c;
    logic [ENTRY_W-1:0] entry_c;

    assign entry_c       = {pc_i, ir_i, acc_i};
    assign timeout_hit_c = (cycle_cnt_o == CNT_W'(TIMEOUT - 1));
    assign state_o       = state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; halt outranks the watchdog
    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_i) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_i) begin
                        state_nxt = ST_HALTED;
                    end else if (en_i && timeout_hit_c) begin
                        state_nxt = ST_TIMEOUT;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Control strobes derived from the current state
    always_comb begin
        push_c = 1'b0;
        pop_c  = 1'b0;
        run_c  = 1'b0;
        if (!clear_i) begin
            case (state)
                ST_RUN: begin
                    run_c  = en_i;
                    push_c = en_i && commit_i;
                end
                ST_HALTED, ST_TIMEOUT: begin
                    pop_c = rd_req_i;
                end
                default: begin
                    run_c = 1'b0;
                end
            endcase
        end
    end

    // Cycle and saturating instruction counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else if (clear_i) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else begin
            if (run_c) begin
                cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            end
            if (push_c && (instr_cnt_o != '1)) begin
                instr_cnt_o <= instr_cnt_o + CNT_W'(1);
            end
        end
    end

    trace_ring_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_i),
        .push     (push_c),
        .pop      (pop_c),
        .wr_data  (entry_c),
        .rd_data  (rd_data_o),
        .rd_valid (rd_valid_o),
        .count    (count_o),
        .overflow (overflow_o)
    );

endmodule
